wb_block_copier: RTL and testbench
==================================

WB_BLOCK_COPIER -- requirements
Module: wb_block_copier

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for wb_ack_i per transaction, range 1..65535.
REQ-003 SHALL have parameter ACC_BASE, default 32'h0000_0000: accelerator base address for the CSR kick.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a copy.
REQ-007 SHALL have port src_addr  in  32  first source word address.
REQ-008 SHALL have port dst_addr  in  32  first destination word address.
REQ-009 SHALL have port len  in  LEN_W  number of words to copy.
REQ-010 SHALL have port busy  out  1  high while a copy is in progress.
REQ-011 SHALL have port done  out  1  one-cycle pulse on successful completion.
REQ-012 SHALL have port err  out  1  one-cycle pulse on ack timeout.
REQ-013 SHALL have Wishbone initiator ports: wb_cyc_o, wb_stb_o, wb_we_o (out 1 each), wb_adr_o (out 32), wb_dat_o (out 32), wb_sel_o (out 4), wb_dat_i (in 32), wb_ack_i (in 1).

Function
REQ-014 SHALL implement states IDLE, RD, WR, KICK, FIN.
REQ-015 In IDLE, start=1 SHALL latch src_addr, dst_addr and len; len=0 SHALL go to FIN, otherwise to RD.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 In RD, the block SHALL drive cyc=stb=1, we=0, adr=current source, sel=4'hF.
REQ-018 On wb_ack_i in RD, the block SHALL capture wb_dat_i into a 32-bit hold register, drop stb and cyc on the next edge, then enter WR.
REQ-019 In WR, the block SHALL drive cyc=stb=we=1, adr=current destination, dat_o=hold register, sel=4'hF.
REQ-020 On wb_ack_i in WR, the block SHALL increment both addresses by 1 (32-bit wrap), decrement the remaining count, and go to RD if the count is nonzero, else to KICK.
REQ-021 stb SHALL be deasserted for at least one cycle between consecutive transactions, so the target's registered ack is never double-counted.
REQ-022 wb_ack_i outside RD/WR/KICK, or while stb=0, SHALL be ignored.
REQ-023 Each RD/WR/KICK transaction SHALL have a wait counter cleared at stb assertion; reaching TIMEOUT cycles without ack SHALL drop cyc/stb, pulse err, and return to IDLE without done.
REQ-024 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-025 At most one transaction SHALL be outstanding; no pipelined or burst cycles.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE and set busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o to 0 and wb_adr_o, wb_dat_o, wb_sel_o to 0.
REQ-027 Reset mid-transaction SHALL abort it; cyc/stb SHALL be low on the first edge after reset, with no done or err pulse.

Configuration
REQ-028 With macro WB_BLOCK_COPIER_KICK_EN defined, KICK SHALL write 32'h0000_0001 to ACC_BASE+32'hFE00 (sel=4'h3, we=1) and go to FIN on ack.
REQ-029 Without WB_BLOCK_COPIER_KICK_EN, KICK SHALL issue no bus cycle and go directly to FIN.
REQ-030 With the macro, len=0 SHALL still skip the kick and go directly to FIN.

Verification
REQ-031 start, src=0x100, dst=0x0, len=3, zero-wait target -> 3 read/write pairs with data copied in order; done one cycle; busy low afterward.
REQ-032 Same stimulus, target ack delayed 5 cycles -> identical data, cyc/stb held until ack, no err.
REQ-033 TIMEOUT=8, target never acks the second write -> err pulse 8 cycles after that stb, cyc low, no done, busy low.
REQ-034 len=0 -> no wb_cyc_o assertion; done one cycle after start.
REQ-035 With KICK_EN, len=1 -> final write adr=0xFE00, dat=0x1, sel=4'h3; then done.
REQ-036 rst_n=0 during the WR of word 2 of len=4 -> cyc/stb low on the next edge; a subsequent start completes normally.

Source files
------------

// File: rtl/wb_block_copier_if.sv
// Wishbone initiator bus bundle for wb_block_copier.
interface wb_block_copier_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_block_copier.sv
// Word-by-word Wishbone block copier with ack timeout.
// Optional accelerator kick write after a copy: define WB_BLOCK_COPIER_KICK_EN.
module wb_block_copier #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ACC_BASE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  wb_block_copier_if.master wb
);

  localparam int unsigned      WAIT_W    = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

`ifdef WB_BLOCK_COPIER_KICK_EN
  localparam logic [31:0] KICK_ADR = ACC_BASE + 32'h0000_FE00;
`else
  // Kick target has no use when the kick write is compiled out.
  logic unused_acc;
  assign unused_acc = ^ACC_BASE;
`endif

  typedef enum logic [2:0] {IDLE, RD, WR, KICK, FIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      src_q, dst_q, hold_q;
  logic [LEN_W-1:0] remain_q;
  logic [WAIT_W-1:0] wait_q;
  logic             ack_c, timeout_c;

  logic        cyc_nxt, stb_nxt, we_nxt, busy_nxt, done_nxt, err_nxt;
  logic [31:0] adr_nxt, dat_nxt;
  logic [3:0]  sel_nxt;

  // Acks only count against our own live strobe.
  assign ack_c     = wb.wb_stb_o && wb.wb_ack_i;
  assign timeout_c = wb.wb_stb_o && !wb.wb_ack_i && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len == '0) ? FIN : RD;
      RD: begin
        if (timeout_c)  state_nxt = IDLE;
        else if (ack_c) state_nxt = WR;
      end
      WR: begin
        if (timeout_c)  state_nxt = IDLE;
        else if (ack_c) state_nxt = (remain_q == LEN_W'(1)) ? KICK : RD;
      end
`ifdef WB_BLOCK_COPIER_KICK_EN
      KICK: begin
        if (timeout_c)  state_nxt = IDLE;
        else if (ack_c) state_nxt = FIN;
      end
`else
      KICK: state_nxt = FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus is driven only while staying in a bus state, so every state change
  // (and the first cycle in a new one) leaves stb low for a cycle.
  always_comb begin
    cyc_nxt  = 1'b0;
    stb_nxt  = 1'b0;
    we_nxt   = 1'b0;
    adr_nxt  = 32'h0;
    dat_nxt  = 32'h0;
    sel_nxt  = 4'h0;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == FIN);
    err_nxt  = timeout_c;
    if (state_nxt == state) begin
      unique case (state)
        RD: begin
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          adr_nxt = src_q;
          sel_nxt = 4'hF;
        end
        WR: begin
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          we_nxt  = 1'b1;
          adr_nxt = dst_q;
          dat_nxt = hold_q;
          sel_nxt = 4'hF;
        end
`ifdef WB_BLOCK_COPIER_KICK_EN
        KICK: begin
          cyc_nxt = 1'b1;
          stb_nxt = 1'b1;
          we_nxt  = 1'b1;
          adr_nxt = KICK_ADR;
          dat_nxt = 32'h0000_0001;
          sel_nxt = 4'h3;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= 32'h0;
      wb.wb_dat_o <= 32'h0;
      wb.wb_sel_o <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb.wb_cyc_o <= cyc_nxt;
      wb.wb_stb_o <= stb_nxt;
      wb.wb_we_o  <= we_nxt;
      wb.wb_adr_o <= adr_nxt;
      wb.wb_dat_o <= dat_nxt;
      wb.wb_sel_o <= sel_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
    end
  end

  // Copy pointers, hold register and per-transaction wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      hold_q   <= 32'h0;
      remain_q <= '0;
      wait_q   <= '0;
    end else begin
      if (state == IDLE && start) begin
        src_q    <= src_addr;
        dst_q    <= dst_addr;
        remain_q <= len;
      end
      if (state == RD && ack_c) hold_q <= wb.wb_dat_i;
      if (state == WR && ack_c) begin
        src_q    <= src_q + 32'd1;
        dst_q    <= dst_q + 32'd1;
        remain_q <= remain_q - LEN_W'(1);
      end
      wait_q <= (wb.wb_stb_o && !wb.wb_ack_i) ? wait_q + WAIT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_wb_block_copier.sv
// Scoreboard bench for wb_block_copier against a registered-ack Wishbone target.
module tb_wb_block_copier;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len = 16'h0;
  logic        busy, done, err;

  wb_block_copier_if bus();

  wb_block_copier #(.LEN_W(16), .TIMEOUT(8), .ACC_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .wb(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Target: read data derived from address, registered ack after ack_delay.
  int unsigned ack_delay = 0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_adr = 32'h0;
  int unsigned wcnt = 0;

  assign bus.wb_dat_i = {16'hA5A5, bus.wb_adr_o[15:0]};

  always @(posedge clk) begin
    if (!rst_n || !(bus.wb_cyc_o && bus.wb_stb_o) || bus.wb_ack_i) begin
      bus.wb_ack_i <= 1'b0;
      wcnt <= 0;
    end else if (wcnt >= ack_delay && !(hang_en && bus.wb_we_o && bus.wb_adr_o == hang_adr)) begin
      bus.wb_ack_i <= 1'b1;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Monitor
  int   n_done = 0, n_err = 0, n_cyc = 0, neg_no = 0, rise_no = 0;
  logic stb_p = 1'b0, ack_p = 1'b0, done_p = 1'b0, cyc_p = 1'b0;

  always @(negedge clk) begin
    neg_no++;
    if (rst_n) begin
      if (bus.wb_stb_o && !stb_p) rise_no = neg_no;
      if (bus.wb_cyc_o && !cyc_p) n_cyc++;
      if (bus.wb_stb_o && bus.wb_ack_i) begin
        if (bus.wb_we_o) begin
          if (exp_wr.size() == 0) chk(1'b0, "wr_unexpected", bus.wb_adr_o, 32'h0);
          else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk(bus.wb_adr_o == w.adr, "wr_adr", bus.wb_adr_o, w.adr);
            chk(bus.wb_dat_o == w.dat, "wr_dat", bus.wb_dat_o, w.dat);
            chk(bus.wb_sel_o == w.sel, "wr_sel", 32'(bus.wb_sel_o), 32'(w.sel));
          end
        end else begin
          if (exp_rd.size() == 0) chk(1'b0, "rd_unexpected", bus.wb_adr_o, 32'h0);
          else begin
            logic [31:0] a;
            a = exp_rd.pop_front();
            chk(bus.wb_adr_o == a, "rd_adr", bus.wb_adr_o, a);
            chk(bus.wb_sel_o == 4'hF, "rd_sel", 32'(bus.wb_sel_o), 32'hF);
          end
        end
      end
      if (stb_p && ack_p)
        chk(!bus.wb_stb_o, "stb_gap", 32'(bus.wb_stb_o), 32'h0);
      if (stb_p && !ack_p && !err)
        chk(bus.wb_stb_o && bus.wb_cyc_o, "stb_held", 32'(bus.wb_stb_o), 32'h1);
      if (done) begin
        n_done++;
        chk(!done_p, "done_width", 32'(done_p), 32'h0);
      end
      if (err) begin
        n_err++;
        chk(neg_no - rise_no == 8, "err_latency", 32'(neg_no - rise_no), 32'd8);
      end
    end
    stb_p  = bus.wb_stb_o;
    ack_p  = bus.wb_ack_i;
    done_p = done;
    cyc_p  = bus.wb_cyc_o;
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.adr = a; w.dat = d; w.sel = s;
    exp_wr.push_back(w);
  endtask

  task automatic push_kick();
`ifdef WB_BLOCK_COPIER_KICK_EN
    push_wr(32'h0000_FE00, 32'h0000_0001, 4'h3);
`endif
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int exp_done, input int exp_err, input bit poke, input string tag);
    int d0, e0;
    d0 = n_done; e0 = n_err;
    pulse_start(s, d, n);
    chk(busy == 1'b1, {tag, "_busy"}, 32'(busy), 32'h1);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; src_addr = 32'h999; dst_addr = 32'h777; len = 16'd5;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk(!busy, {tag, "_idle"}, 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk(n_done - d0 == exp_done, {tag, "_done_cnt"}, 32'(n_done - d0), 32'(exp_done));
    chk(n_err - e0 == exp_err, {tag, "_err_cnt"}, 32'(n_err - e0), 32'(exp_err));
    chk(!bus.wb_cyc_o, {tag, "_cyc_low"}, 32'(bus.wb_cyc_o), 32'h0);
    chk(exp_wr.size() == 0, {tag, "_wr_left"}, 32'(exp_wr.size()), 32'h0);
    chk(exp_rd.size() == 0, {tag, "_rd_left"}, 32'(exp_rd.size()), 32'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    bit found;
    repeat (3) @(negedge clk);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
    chk(done == 1'b0, "rst_done", 32'(done), 32'h0);
    chk(err == 1'b0, "rst_err", 32'(err), 32'h0);
    chk(bus.wb_cyc_o == 1'b0, "rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk(bus.wb_stb_o == 1'b0, "rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk(bus.wb_we_o == 1'b0, "rst_we", 32'(bus.wb_we_o), 32'h0);
    chk(bus.wb_adr_o == 32'h0, "rst_adr", bus.wb_adr_o, 32'h0);
    chk(bus.wb_dat_o == 32'h0, "rst_dat", bus.wb_dat_o, 32'h0);
    chk(bus.wb_sel_o == 4'h0, "rst_sel", 32'(bus.wb_sel_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait copy of three words, with a start pulse while busy.
    ack_delay = 0;
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h101); exp_rd.push_back(32'h102);
    push_wr(32'h0, 32'hA5A5_0100, 4'hF);
    push_wr(32'h1, 32'hA5A5_0101, 4'hF);
    push_wr(32'h2, 32'hA5A5_0102, 4'hF);
    push_kick();
    run_copy(32'h100, 32'h0, 16'd3, 1, 0, 1'b1, "zero_wait");

    // Same copy with a slow target.
    ack_delay = 5;
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h101); exp_rd.push_back(32'h102);
    push_wr(32'h0, 32'hA5A5_0100, 4'hF);
    push_wr(32'h1, 32'hA5A5_0101, 4'hF);
    push_wr(32'h2, 32'hA5A5_0102, 4'hF);
    push_kick();
    run_copy(32'h100, 32'h0, 16'd3, 1, 0, 1'b0, "slow_ack");

    // Second write never acked: timeout.
    ack_delay = 0; hang_en = 1'b1; hang_adr = 32'h1;
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h101);
    push_wr(32'h0, 32'hA5A5_0100, 4'hF);
    run_copy(32'h100, 32'h0, 16'd3, 0, 1, 1'b0, "timeout");
    hang_en = 1'b0;

    // Zero length: no bus cycle, done one cycle after start.
    c0 = n_cyc;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h500; dst_addr = 32'h600; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk(done == 1'b0, "len0_done_early", 32'(done), 32'h0);
    @(negedge clk);
    chk(done == 1'b1, "len0_done", 32'(done), 32'h1);
    chk(busy == 1'b0, "len0_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk(n_cyc == c0, "len0_no_cyc", 32'(n_cyc - c0), 32'h0);

    // Single word, followed by the kick when it is built in.
    exp_rd.push_back(32'h10);
    push_wr(32'h20, 32'hA5A5_0010, 4'hF);
    push_kick();
    run_copy(32'h10, 32'h20, 16'd1, 1, 0, 1'b0, "len1");

    // Reset during the write of word 2, then a clean copy.
    ack_delay = 5;
    exp_rd.push_back(32'h200); exp_rd.push_back(32'h201);
    push_wr(32'h40, 32'hA5A5_0200, 4'hF);
    pulse_start(32'h200, 32'h40, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (bus.wb_stb_o && bus.wb_we_o && bus.wb_adr_o == 32'h41) found = 1'b1;
      else @(negedge clk);
    end
    chk(found, "rst_mid_reach", 32'(found), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk(!bus.wb_cyc_o, "rst_mid_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk(!bus.wb_stb_o, "rst_mid_stb", 32'(bus.wb_stb_o), 32'h0);
    chk(!done, "rst_mid_done", 32'(done), 32'h0);
    chk(!err, "rst_mid_err", 32'(err), 32'h0);
    chk(!busy, "rst_mid_busy", 32'(busy), 32'h0);
    chk(exp_wr.size() == 0, "rst_mid_wr_left", 32'(exp_wr.size()), 32'h0);
    chk(exp_rd.size() == 0, "rst_mid_rd_left", 32'(exp_rd.size()), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    exp_rd.push_back(32'h300); exp_rd.push_back(32'h301);
    push_wr(32'h80, 32'hA5A5_0300, 4'hF);
    push_wr(32'h81, 32'hA5A5_0301, 4'hF);
    push_kick();
    run_copy(32'h300, 32'h80, 16'd2, 1, 0, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
